// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO.
// Holds default geometry, the pointer struct and the pointer/address helpers.
// Optional feature macro used by this block: SYNC_FIFO_FWFT_EN (first-word-fall-through read).

package sync_fifo_pkg;

    // Default geometry. This matches the fixed 64x32 block it replaces.
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 64;

    // The pointer address field is sized for the largest supported depth.
    // Only the low AW bits are ever non-zero, because the increment wraps at DEPTH.
    localparam int PTR_ADDR_W = 32;

    // A FIFO pointer is the wrap bit plus the storage address.
    // The wrap bit flips on every pass through the array.
    // Equal pointers mean empty. Equal addresses with different wrap bits mean full.
    typedef struct packed {
        logic                  wrap;
        logic [PTR_ADDR_W-1:0] addr;
    } fifo_ptr_t;

    // Ceiling log2, usable in constant expressions (clog2(1) = 0).
    function automatic int clog2(input int unsigned n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (((n - 32'd1) >> i) != 32'd0) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Advance a pointer by one entry.
    // The address wraps at depth-1 and the wrap bit toggles at the same time.
    // For a power-of-two depth this is the natural (AW+1)-bit roll-over,
    // so 2*DEPTH-1 goes back to 0.
    function automatic fifo_ptr_t ptr_inc(input fifo_ptr_t p, input int unsigned depth);
        fifo_ptr_t n;
        n = p;
        if (p.addr == (depth - 32'd1)) begin
            n.addr = '0;
            n.wrap = ~p.wrap;
        end else begin
            n.addr = p.addr + 32'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake, data and status bundle between a FIFO and its producer/consumer.
// slave is the FIFO side; master is the side that writes and pops.
// Optional feature macro: SYNC_FIFO_FWFT_EN (changes r_data/r_data_valid timing only).

interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int AW = clog2(DEPTH);

    // Write side
    logic             w_valid;
    logic [WIDTH-1:0] w_data;
    logic             w_ready;

    // Read side
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_data_valid;

    // Status
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [AW:0]      level;
    logic             overflow;
    logic             underflow;

    modport slave (
        input  w_valid, w_data, r_valid,
        output w_ready, r_data, r_data_valid,
        output full, empty, almost_full, almost_empty, level,
        output overflow, underflow
    );

    modport master (
        output w_valid, w_data, r_valid,
        input  w_ready, r_data, r_data_valid,
        input  full, empty, almost_full, almost_empty, level,
        input  overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo: WIDTH x DEPTH, one write port and one read port.
// Write is synchronous. Read is registered (1 cycle) by default,
// or asynchronous when SYNC_FIFO_FWFT_EN is defined.
// No backpressure here: the control block only issues legal accesses.

module sync_fifo_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    // Contents are intentionally not reset; they are undefined until written.
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port: capture the accepted word at the write address.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN

    // The head word is visible combinationally.
    // Read enable and reset have no role on this port.
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = re_i ^ rst_i;
    assign rdata_o        = mem_q[raddr_i];

`else

    logic [WIDTH-1:0] rdata_q;

    // Read port: load only on an accepted pop, so the output holds its
    // last popped value between pops. It clears to zero on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

`endif

endmodule

// File: rtl/sync_fifo.sv
// Parametrised single-clock FIFO with level, almost flags and overflow/underflow pulses.
// Latency: a pop returns data 1 cycle later (r_data_valid pulse). With SYNC_FIFO_FWFT_EN
// the head word shows on r_data whenever the FIFO is not empty.
// Backpressure: w_ready = !full. Writes when full and pops when empty are dropped and
// flagged by a one-cycle overflow/underflow pulse.
// DEPTH must be a power of two and >= 4; AFULL_TH and AEMPTY_TH must lie in 0..DEPTH.

module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_TH  = DEPTH - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic      clk,
    input  logic      m_rst,
    sync_fifo_if.slave bus
);

    localparam int AW = clog2(DEPTH);

    // Thresholds resized to the level width once, so the compares stay AW+1 bits wide.
    localparam logic [AW:0] AFULL_LVL  = (AW + 1)'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_LVL = (AW + 1)'(AEMPTY_TH);

    fifo_ptr_t wr_ptr_q;
    fifo_ptr_t wr_ptr_d;
    fifo_ptr_t rd_ptr_q;
    fifo_ptr_t rd_ptr_d;

    logic        full_w;
    logic        empty_w;
    logic        wr_acc;
    logic        rd_acc;
    logic [AW:0] level_w;
    logic        overflow_q;
    logic        underflow_q;

    logic [WIDTH-1:0] ram_rdata;

    // ------------------------------------------------------------------
    // Status decode
    // ------------------------------------------------------------------
    // All status comes from the registered pointers.
    // So level and every flag change together on the same edge.
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q.wrap != rd_ptr_q.wrap) && (wr_ptr_q.addr == rd_ptr_q.addr);

    // Occupancy is the difference of the (AW+1)-bit pointers.
    // Modulo arithmetic handles the wrap.
    assign level_w = {wr_ptr_q.wrap, wr_ptr_q.addr[AW-1:0]}
                   - {rd_ptr_q.wrap, rd_ptr_q.addr[AW-1:0]};

    // Accept decisions use the flags as they stand at the start of the cycle.
    // A pop while full frees space only for the next cycle.
    // A write while empty makes data poppable only next cycle, so there is no bypass.
    assign wr_acc = bus.w_valid && !full_w;
    assign rd_acc = bus.r_valid && !empty_w;

    // ------------------------------------------------------------------
    // Pointers
    // ------------------------------------------------------------------
    // Next-state: each pointer advances by one entry when its side is accepted.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = ptr_inc(wr_ptr_q, DEPTH);
        end
        if (rd_acc) begin
            rd_ptr_d = ptr_inc(rd_ptr_q, DEPTH);
        end
    end

    // Pointer registers: reset discards all contents at once by equalising both pointers.
    always_ff @(posedge clk or posedge m_rst) begin
        if (m_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Error pulses
    // ------------------------------------------------------------------
    // Register any attempt that hit a full or empty FIFO.
    // Each pulse lasts one cycle per offending request.
    always_ff @(posedge clk or posedge m_rst) begin
        if (m_rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= bus.w_valid && full_w;
            underflow_q <= bus.r_valid && empty_w;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    sync_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk),
        .rst_i   (m_rst),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q.addr[AW-1:0]),
        .wdata_i (bus.w_data),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q.addr[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Read data qualification
    // ------------------------------------------------------------------
`ifdef SYNC_FIFO_FWFT_EN

    // The head word is always presented.
    // It is valid whenever anything is stored.
    assign bus.r_data_valid = !empty_w;

`else

    logic r_data_valid_q;

    // Pulse valid for exactly the cycle after an accepted pop,
    // which is when the registered RAM output holds the popped word.
    always_ff @(posedge clk or posedge m_rst) begin
        if (m_rst) begin
            r_data_valid_q <= 1'b0;
        end else begin
            r_data_valid_q <= rd_acc;
        end
    end

    assign bus.r_data_valid = r_data_valid_q;

`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.r_data       = ram_rdata;
    assign bus.w_ready      = !full_w;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.level        = level_w;
    assign bus.almost_full  = (level_w >= AFULL_LVL);
    assign bus.almost_empty = (level_w <= AEMPTY_LVL);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo (WIDTH=32, DEPTH=8, AFULL_TH=6, AEMPTY_TH=2).
// The reference model is a plain queue; popped words are queued as expectations with a due cycle.
// Status flags are compared against the model's occupancy after every clock edge.

module tb_sync_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int AFT   = 6;
    localparam int AET   = 2;

    typedef struct {
        logic [WIDTH-1:0] dat;
        int               due;
    } exp_t;

    logic clk;
    logic m_rst;
    int   cyc;
    int   checks;
    int   failures;

    // Reference model state
    logic [WIDTH-1:0] mq[$];     // stored words, head first
    exp_t             exp_q[$];  // popped words awaiting the r_data_valid pulse
    logic [WIDTH-1:0] last_pop;  // word r_data should hold
    bit               exp_rvld;
    bit               exp_ovf;
    bit               exp_udf;

    sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    sync_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFT),
        .AEMPTY_TH (AET)
    ) dut (
        .clk   (clk),
        .m_rst (m_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare every status output against the model's occupancy
    task automatic check_flags();
        int lvl;
        lvl = mq.size();
        chk("level",        64'(bus.level),  64'(lvl));
        chk("empty",        bus.empty,        lvl == 0);
        chk("full",         bus.full,         lvl == DEPTH);
        chk("w_ready",      bus.w_ready,      lvl != DEPTH);
        chk("almost_full",  bus.almost_full,  lvl >= AFT);
        chk("almost_empty", bus.almost_empty, lvl <= AET);
        chk("overflow",     bus.overflow,     exp_ovf);
        chk("underflow",    bus.underflow,    exp_udf);
`ifdef SYNC_FIFO_FWFT_EN
        chk("r_data_valid", bus.r_data_valid, lvl != 0);
        if (lvl != 0) chk("r_data_head", bus.r_data, mq[0]);
`else
        chk("r_data_valid", bus.r_data_valid, exp_rvld);
        chk("r_data_hold",  bus.r_data,       last_pop);
`endif
    endtask

    // Issue one cycle of requests, update the model, then check after the edge
    task automatic step(input bit w, input logic [WIDTH-1:0] wd, input bit r);
        bit   wr_ok;
        bit   rd_ok;
        exp_t e;
        bus.w_valid = w;
        bus.w_data  = wd;
        bus.r_valid = r;
        wr_ok   = w && (mq.size() != DEPTH);
        rd_ok   = r && (mq.size() != 0);
        exp_ovf = w && (mq.size() == DEPTH);
        exp_udf = r && (mq.size() == 0);
        exp_rvld = rd_ok;
        if (rd_ok) begin
            e.dat    = mq.pop_front();
            e.due    = cyc + 1;
            last_pop = e.dat;
`ifndef SYNC_FIFO_FWFT_EN
            exp_q.push_back(e);
`endif
        end
        if (wr_ok) mq.push_back(wd);
        @(posedge clk);
        #1;
        check_flags();
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        last_pop = '0;
        exp_rvld = 1'b0;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
    endtask

    // Assert reset between edges and check that it takes effect without a clock.
    // Called just after an edge.
    task automatic mid_reset();
        #1;
        m_rst       = 1'b1;
        bus.w_valid = 1'b0;
        bus.r_valid = 1'b0;
        model_reset();
        #1;
        check_flags();
        @(posedge clk);
        #2;
        m_rst = 1'b0;
        @(posedge clk);
        #1;
        check_flags();
    endtask

    // Monitor: every r_data_valid pulse must match the oldest expected pop, on its due cycle
`ifndef SYNC_FIFO_FWFT_EN
    always @(negedge clk) begin
        if (!m_rst && bus.r_data_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_rvalid actual=1 expected=0 r_data=%0h (cycle %0d)", bus.r_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("r_data", bus.r_data, e.dat);
                chk("r_data_time", 64'(cyc), 64'(e.due));
            end
        end
    end
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        m_rst       = 1'b0;
        bus.w_valid = 1'b0;
        bus.w_data  = '0;
        bus.r_valid = 1'b0;
        model_reset();

        // 1. reset values, checked both during reset and after an idle cycle
        #1 m_rst = 1'b1;
        #2 check_flags();
        @(posedge clk);
        #2 m_rst = 1'b0;
        @(posedge clk);
        #1 check_flags();
        step(0, '0, 0);

        // 2. fill to full, then write once more to get an overflow pulse
        for (int i = 0; i < DEPTH; i++) step(1, 32'hA0 + 32'(i), 0);
        step(1, 32'hFF, 0);
        step(0, '0, 0);

        // 3. drain in order, then pop once more to get an underflow pulse
        for (int i = 0; i < DEPTH; i++) step(0, '0, 1);
        step(0, '0, 1);
        step(0, '0, 0);

        // 4. level 4, simultaneous traffic across the pointer wrap, then read+write at full
        for (int i = 0; i < 4; i++) step(1, 32'hB0 + 32'(i), 0);
        for (int i = 0; i < 20; i++) step(1, 32'hC0 + 32'(i), 1);
        for (int i = 0; i < 4; i++) step(1, 32'hD0 + 32'(i), 0);
        step(1, 32'hEE, 1);
        while (mq.size() != 0) step(0, '0, 1);
        step(0, '0, 0);

        // 5. reset at level 5; fresh data must follow, not stale data
        for (int i = 0; i < 5; i++) step(1, 32'h50 + 32'(i), 0);
        mid_reset();
        step(1, 32'h55, 0);
        step(0, '0, 1);
        step(0, '0, 0);

        // Randomised traffic in fill-biased, drain-biased and balanced phases
        for (int i = 0; i < 1500; i++) begin
            int pw;
            int pr;
            case ((i / 150) % 3)
                0:       begin pw = 80; pr = 30; end
                1:       begin pw = 30; pr = 80; end
                default: begin pw = 60; pr = 60; end
            endcase
            step($urandom_range(99) < pw, $urandom, $urandom_range(99) < pr);
            if (i == 700) mid_reset();
        end
        step(0, '0, 0);
        step(0, '0, 0);

        chk("pending_pops", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Parametrised single-clock FIFO. It succeeds the fixed 64x32 storage block: width and depth are generic, it tracks its own pointers, and it reports full/empty, almost-full/almost-empty, fill level and error flags. Used as the general buffering element between same-clock stages; dual-clock crossings keep their own wrapper.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 64, number of entries; power of two, >=4
AW, $clog2(DEPTH), address width (derived, not overridden)
AFULL_TH, DEPTH-4, almost_full asserted when level >= AFULL_TH
AEMPTY_TH, 4, almost_empty asserted when level <= AEMPTY_TH

Ports:
clk  in  1  single clock, rising edge
m_rst  in  1  asynchronous reset, active-high
w_valid  in  1  write request
w_data  in  WIDTH  write data
w_ready  out  1  write will be accepted this cycle (= !full)
r_valid  in  1  read/pop request
r_data  out  WIDTH  read data
r_data_valid  out  1  r_data holds a newly popped word (see Behaviour)
full  out  1  level == DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= AFULL_TH
almost_empty  out  1  level <= AEMPTY_TH
level  out  AW+1  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: write attempted while full
underflow  out  1  one-cycle pulse: read attempted while empty

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream): wr_ptr=rd_ptr=0, level=0, empty=1, full=0, almost_empty=1, almost_full=0, r_data=0, r_data_valid=0, overflow=underflow=0. Storage array is not reset; contents are undefined after reset.
- Pointers are AW+1 bits. Address = low AW bits. MSB is the wrap bit. full = (addr equal, MSB differ). empty = (pointers equal). Pointers wrap naturally from 2*DEPTH-1 to 0.
- Write accept: w_valid && !full, using full as sampled at cycle start. Data written at wr_ptr[AW-1:0], wr_ptr+1.
- Read accept: r_valid && !empty, using empty as sampled at cycle start. rd_ptr+1.
- Default (non-FWFT) read latency is 1. On the edge after an accepted read, r_data = word popped and r_data_valid = 1 for exactly one cycle. Otherwise r_data holds its last value and r_data_valid = 0.
- Simultaneous accepted read and write: level unchanged. When full, the read is accepted and the write rejected (overflow pulses). When empty, the write is accepted and the read rejected (underflow pulses). There is no write-to-read bypass.
- level updates by +1, -1 or 0 per cycle. All flags are registered or derived from registered pointers and are valid in the same cycle as level.
- overflow = registered (w_valid && full). underflow = registered (r_valid && empty). Rejected requests do not alter state.
- Reset asserted mid-operation discards all contents immediately. Outputs take their reset values asynchronously.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN.
- Defined: first-word-fall-through. r_data is the head word (storage read asynchronously at rd_ptr) whenever !empty. r_data_valid = !empty (combinational from registered pointers). r_valid pops the head; the next word appears in the same cycle the pointer advances. Underflow and flag rules are unchanged. r_data is don't-care when empty.
- Undefined: registered 1-cycle read as described above.

Decomposition:
- Package sync_fifo_pkg holds:
  - clog2 helper function
  - default WIDTH/DEPTH localparams
  - typedef for the pointer struct {wrap bit, addr}
- One sub-module, sync_fifo_ram: 1 write port, 1 read port, WIDTH x DEPTH, synchronous write. Read is synchronous by default, or asynchronous under SYNC_FIFO_FWFT_EN. Control, pointers and flags stay in sync_fifo.

Test Plan (WIDTH=32, DEPTH=8, AFULL_TH=6, AEMPTY_TH=2, non-FWFT unless noted):
1. Reset then idle -> empty=1, almost_empty=1, level=0, full=0, r_data=0, r_data_valid=0.
2. Write 0xA0..0xA7 on 8 cycles -> level counts 1..8; almost_full rises at level 6; full=1, w_ready=0 after the 8th. A 9th write (0xFF) -> overflow pulses 1 cycle, level stays 8.
3. From full, pop 8 times -> r_data 0xA0..0xA7 in order, each one cycle after its pop, with r_data_valid pulsing. Then empty=1. A further pop -> underflow pulse, r_data holds 0xA7.
4. Fill 4, then run simultaneous read+write for 20 cycles (pointer wrap) -> level constant at 4, data order preserved across wrap; at full, simultaneous read+write -> read accepted, write rejected, level 7.
5. Assert m_rst mid-stream at level 5 -> all flags/level return to reset values without a clock edge; the next write/read returns the new data, not stale data.
6. SYNC_FIFO_FWFT_EN: write 0x11 -> next cycle r_data=0x11, r_data_valid=1 with no pop. Pop -> empty=1, r_data_valid=0.
